// File: rtl/cv32e40p_apu_wb_buffer.sv
// APU writeback buffer: merges APU results onto regfile write port B behind LSU priority,
// parking results in a small in-order FIFO and flagging decode hazards against parked entries.
module cv32e40p_apu_wb_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int FLAG_WIDTH = 5,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         apu_rvalid_i,
    input  logic [DATA_WIDTH-1:0]        apu_result_i,
    input  logic [FLAG_WIDTH-1:0]        apu_flags_i,
    input  logic [ADDR_WIDTH-1:0]        apu_waddr_i,
    input  logic                         lsu_we_i,
    input  logic                         is_decoding_i,
    input  logic [3*ADDR_WIDTH-1:0]      read_regs_i,
    input  logic [2:0]                   read_regs_valid_i,
    output logic                         regfile_we_o,
    output logic [ADDR_WIDTH-1:0]        regfile_waddr_o,
    output logic [DATA_WIDTH-1:0]        regfile_wdata_o,
    output logic                         fflags_we_o,
    output logic [FLAG_WIDTH-1:0]        fflags_o,
    output logic                         read_dep_o,
    output logic                         almost_full_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         overflow_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_AF   = CW'(DEPTH - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [FLAG_WIDTH-1:0] r_flags[DEPTH];
    logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
    logic [DEPTH-1:0]      r_vld;
    logic [PW-1:0]         r_rd_ptr, r_wr_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;

    logic w_empty, w_pop, w_bypass, w_push, w_drop, w_enq, w_dep;

    assign w_empty  = (r_count == '0);
    assign w_pop    = !lsu_we_i && !w_empty;
    assign w_bypass = !lsu_we_i && w_empty && apu_rvalid_i;
    assign w_push   = apu_rvalid_i && !w_bypass;
    // A full buffer still accepts a push when the head retires in the same cycle.
    assign w_drop   = w_push && (r_count == CNT_FULL) && !w_pop;
    assign w_enq    = w_push && !w_drop;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_vld      <= '0;
        end else begin
            if (w_pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PW'(1);
            end
            // Set after clear: a full push+pop reuses the slot just retired.
            if (w_enq) begin
                r_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr        <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PW'(1);
            end
            if (w_enq && !w_pop)
                r_count <= r_count + CW'(1);
            else if (w_pop && !w_enq)
                r_count <= r_count - CW'(1);
            if (w_drop)
                r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_data[r_wr_ptr]  <= apu_result_i;
            r_flags[r_wr_ptr] <= apu_flags_i;
            r_addr[r_wr_ptr]  <= apu_waddr_i;
        end
    end

    always_comb begin
        regfile_we_o    = 1'b0;
        regfile_waddr_o = '0;
        regfile_wdata_o = '0;
        fflags_o        = '0;
        if (w_pop) begin
            regfile_we_o    = 1'b1;
            regfile_waddr_o = r_addr[r_rd_ptr];
            regfile_wdata_o = r_data[r_rd_ptr];
            fflags_o        = r_flags[r_rd_ptr];
        end else if (w_bypass) begin
            regfile_we_o    = 1'b1;
            regfile_waddr_o = apu_waddr_i;
            regfile_wdata_o = apu_result_i;
            fflags_o        = apu_flags_i;
        end
    end

    // Entries retiring this cycle still count as hazards; a bypassed input never does.
    always_comb begin
        w_dep = 1'b0;
        for (int e = 0; e < DEPTH; e++)
            for (int i = 0; i < 3; i++)
                if (r_vld[e] && read_regs_valid_i[i] &&
                    read_regs_i[i*ADDR_WIDTH +: ADDR_WIDTH] == r_addr[e])
                    w_dep = 1'b1;
    end

    assign fflags_we_o   = regfile_we_o;
    assign read_dep_o    = is_decoding_i && w_dep;
    assign almost_full_o = (r_count >= CNT_AF);
    assign count_o       = r_count;
    assign overflow_o    = r_overflow;
endmodule

// File: tb/tb_cv32e40p_apu_wb_buffer.sv
// Directed bench for cv32e40p_apu_wb_buffer: inputs change on negedge, outputs sampled 2ns later.
module tb_cv32e40p_apu_wb_buffer;
    localparam int DW = 32, FW = 5, AW = 6, DEPTH = 2, CW = 2;

    logic          clk = 1'b0, rst_ni = 1'b0;
    logic          rvalid = 1'b0, lsu_we = 1'b0, dec = 1'b0;
    logic [DW-1:0] result = '0;
    logic [FW-1:0] flags = '0;
    logic [AW-1:0] waddr = '0;
    logic [3*AW-1:0] rregs = '0;
    logic [2:0]    rvld = '0;
    logic          we, fwe, dep, af, ovf;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [FW-1:0] fo;
    logic [CW-1:0] cnt;

    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    cv32e40p_apu_wb_buffer #(.DATA_WIDTH(DW), .FLAG_WIDTH(FW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .apu_rvalid_i(rvalid), .apu_result_i(result),
        .apu_flags_i(flags), .apu_waddr_i(waddr), .lsu_we_i(lsu_we), .is_decoding_i(dec),
        .read_regs_i(rregs), .read_regs_valid_i(rvld), .regfile_we_o(we),
        .regfile_waddr_o(wa), .regfile_wdata_o(wd), .fflags_we_o(fwe), .fflags_o(fo),
        .read_dep_o(dep), .almost_full_o(af), .count_o(cnt), .overflow_o(ovf)
    );

    // Advance to the next negedge, apply inputs, settle before sampling.
    task automatic step(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [FW-1:0] f, input logic l);
        @(negedge clk);
        rvalid = v; waddr = a; result = d; flags = f; lsu_we = l;
        #2;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        #2;
        n_cmp++; if ({we, fwe} !== 2'b00) begin n_err++; $display("FAIL reset_we got=%b want=00", {we, fwe}); end
        n_cmp++; if (cnt !== 2'd0) begin n_err++; $display("FAIL reset_count got=%0d want=0", cnt); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b want=0", ovf); end
        n_cmp++; if ({wa, wd, fo} !== '0) begin n_err++; $display("FAIL reset_data got=%h/%h/%h want=0", wa, wd, fo); end
        n_cmp++; if (af !== 1'b0) begin n_err++; $display("FAIL reset_af got=%b want=0", af); end
        @(negedge clk); rst_ni = 1'b1;
    endtask

    task automatic test_bypass;
        step(1'b1, 6'd5, 32'hDEADBEEF, 5'h01, 1'b0);
        n_cmp++; if ({we, fwe, wa, wd, fo} !== {2'b11, 6'd5, 32'hDEADBEEF, 5'h01}) begin
            n_err++; $display("FAIL bypass_out got=%b%b/%0d/%h/%h want=11/5/deadbeef/01", we, fwe, wa, wd, fo); end
        step(1'b1, 6'd0, 32'h00000042, 5'h10, 1'b0);
        n_cmp++; if (cnt !== 2'd0) begin n_err++; $display("FAIL bypass_count got=%0d want=0", cnt); end
        n_cmp++; if ({we, wa, wd, fo} !== {1'b1, 6'd0, 32'h42, 5'h10}) begin
            n_err++; $display("FAIL bypass_r0 got=%b/%0d/%h/%h want=1/0/42/10", we, wa, wd, fo); end
        step(1'b0, 6'd0, 32'h0, 5'h0, 1'b0);
        n_cmp++; if ({we, cnt} !== {1'b0, 2'd0}) begin n_err++; $display("FAIL bypass_idle got=%b/%0d want=0/0", we, cnt); end
    endtask

    task automatic test_lsu_park;
        step(1'b1, 6'd3, 32'h11, 5'h03, 1'b1);
        n_cmp++; if (we !== 1'b0) begin n_err++; $display("FAIL park_noweq got=%b want=0", we); end
        step(1'b1, 6'd4, 32'h22, 5'h04, 1'b1);
        n_cmp++; if ({we, cnt} !== {1'b0, 2'd1}) begin n_err++; $display("FAIL park_one got=%b/%0d want=0/1", we, cnt); end
        step(1'b0, 6'd0, 32'h0, 5'h0, 1'b0);
        n_cmp++; if ({cnt, af} !== {2'd2, 1'b1}) begin n_err++; $display("FAIL park_full got=%0d/%b want=2/1", cnt, af); end
        n_cmp++; if ({we, wa, wd, fo} !== {1'b1, 6'd3, 32'h11, 5'h03}) begin
            n_err++; $display("FAIL park_w3 got=%b/%0d/%h/%h want=1/3/11/03", we, wa, wd, fo); end
        step(1'b0, 6'd0, 32'h0, 5'h0, 1'b0);
        n_cmp++; if ({we, wa, wd, cnt, af} !== {1'b1, 6'd4, 32'h22, 2'd1, 1'b1}) begin
            n_err++; $display("FAIL park_w4 got=%b/%0d/%h/%0d/%b want=1/4/22/1/1", we, wa, wd, cnt, af); end
        step(1'b0, 6'd0, 32'h0, 5'h0, 1'b0);
        n_cmp++; if ({we, cnt, af} !== {1'b0, 2'd0, 1'b0}) begin n_err++; $display("FAIL park_drained got=%b/%0d/%b want=0/0/0", we, cnt, af); end
    endtask

    task automatic test_order;
        step(1'b1, 6'd7, 32'h77, 5'h07, 1'b1);
        step(1'b1, 6'd8, 32'h88, 5'h08, 1'b0);
        n_cmp++; if ({we, wa, wd, cnt} !== {1'b1, 6'd7, 32'h77, 2'd1}) begin
            n_err++; $display("FAIL order_r7 got=%b/%0d/%h/%0d want=1/7/77/1", we, wa, wd, cnt); end
        step(1'b0, 6'd0, 32'h0, 5'h0, 1'b0);
        n_cmp++; if ({we, wa, wd, fo, cnt} !== {1'b1, 6'd8, 32'h88, 5'h08, 2'd1}) begin
            n_err++; $display("FAIL order_r8 got=%b/%0d/%h/%h/%0d want=1/8/88/08/1", we, wa, wd, fo, cnt); end
        step(1'b0, 6'd0, 32'h0, 5'h0, 1'b0);
        n_cmp++; if ({we, cnt} !== {1'b0, 2'd0}) begin n_err++; $display("FAIL order_empty got=%b/%0d want=0/0", we, cnt); end
    endtask

    task automatic test_full_push_pop;
        step(1'b1, 6'd20, 32'h2020, 5'h14, 1'b1);
        step(1'b1, 6'd21, 32'h2121, 5'h15, 1'b1);
        step(1'b1, 6'd22, 32'h2222, 5'h16, 1'b0);
        n_cmp++; if ({we, wa, wd, cnt} !== {1'b1, 6'd20, 32'h2020, 2'd2}) begin
            n_err++; $display("FAIL fpp_r20 got=%b/%0d/%h/%0d want=1/20/2020/2", we, wa, wd, cnt); end
        step(1'b0, 6'd0, 32'h0, 5'h0, 1'b0);
        n_cmp++; if ({we, wa, wd, cnt, ovf} !== {1'b1, 6'd21, 32'h2121, 2'd2, 1'b0}) begin
            n_err++; $display("FAIL fpp_r21 got=%b/%0d/%h/%0d/%b want=1/21/2121/2/0", we, wa, wd, cnt, ovf); end
        step(1'b0, 6'd0, 32'h0, 5'h0, 1'b0);
        n_cmp++; if ({we, wa, wd, cnt} !== {1'b1, 6'd22, 32'h2222, 2'd1}) begin
            n_err++; $display("FAIL fpp_r22 got=%b/%0d/%h/%0d want=1/22/2222/1", we, wa, wd, cnt); end
        step(1'b0, 6'd0, 32'h0, 5'h0, 1'b0);
    endtask

    task automatic test_read_dep;
        step(1'b1, 6'd9, 32'h99, 5'h09, 1'b1);
        step(1'b0, 6'd0, 32'h0, 5'h0, 1'b1);
        dec = 1'b1; rregs = {6'd9, 6'd2, 6'd1}; rvld = 3'b100; #1;
        n_cmp++; if (dep !== 1'b1) begin n_err++; $display("FAIL dep_hit got=%b want=1", dep); end
        rvld = 3'b011; #1;
        n_cmp++; if (dep !== 1'b0) begin n_err++; $display("FAIL dep_slotinvalid got=%b want=0", dep); end
        rvld = 3'b100; dec = 1'b0; #1;
        n_cmp++; if (dep !== 1'b0) begin n_err++; $display("FAIL dep_nodecode got=%b want=0", dep); end
        dec = 1'b1; rregs = {6'd1, 6'd9, 6'd2}; rvld = 3'b010; #1;
        n_cmp++; if (dep !== 1'b1) begin n_err++; $display("FAIL dep_slot1 got=%b want=1", dep); end
        // Popping entry is still reported.
        step(1'b0, 6'd0, 32'h0, 5'h0, 1'b0);
        n_cmp++; if ({dep, we, wa} !== {1'b1, 1'b1, 6'd9}) begin n_err++; $display("FAIL dep_popping got=%b/%b/%0d want=1/1/9", dep, we, wa); end
        // Bypassed input with matching address is not reported.
        step(1'b1, 6'd9, 32'h1234, 5'h0, 1'b0);
        n_cmp++; if ({dep, we, cnt} !== {1'b0, 1'b1, 2'd0}) begin n_err++; $display("FAIL dep_bypass got=%b/%b/%0d want=0/1/0", dep, we, cnt); end
        dec = 1'b0; rvld = '0;
        step(1'b0, 6'd0, 32'h0, 5'h0, 1'b0);
    endtask

    task automatic test_overflow;
        step(1'b1, 6'd10, 32'hA, 5'h0A, 1'b1);
        step(1'b1, 6'd11, 32'hB, 5'h0B, 1'b1);
        step(1'b1, 6'd12, 32'hC, 5'h0C, 1'b1);
        n_cmp++; if ({cnt, ovf} !== {2'd2, 1'b0}) begin n_err++; $display("FAIL ovf_pre got=%0d/%b want=2/0", cnt, ovf); end
        step(1'b0, 6'd0, 32'h0, 5'h0, 1'b1);
        n_cmp++; if ({cnt, ovf, we} !== {2'd2, 1'b1, 1'b0}) begin n_err++; $display("FAIL ovf_set got=%0d/%b/%b want=2/1/0", cnt, ovf, we); end
        step(1'b0, 6'd0, 32'h0, 5'h0, 1'b0);
        n_cmp++; if ({we, wa, wd, ovf} !== {1'b1, 6'd10, 32'hA, 1'b1}) begin
            n_err++; $display("FAIL ovf_r10 got=%b/%0d/%h/%b want=1/10/a/1", we, wa, wd, ovf); end
        step(1'b0, 6'd0, 32'h0, 5'h0, 1'b0);
        n_cmp++; if ({we, wa, wd, cnt} !== {1'b1, 6'd11, 32'hB, 2'd1}) begin
            n_err++; $display("FAIL ovf_r11 got=%b/%0d/%h/%0d want=1/11/b/1", we, wa, wd, cnt); end
        step(1'b0, 6'd0, 32'h0, 5'h0, 1'b0);
        n_cmp++; if ({we, cnt, ovf} !== {1'b0, 2'd0, 1'b1}) begin n_err++; $display("FAIL ovf_sticky got=%b/%0d/%b want=0/0/1", we, cnt, ovf); end
    endtask

    task automatic test_async_reset;
        step(1'b1, 6'd30, 32'h30, 5'h1E, 1'b1);
        step(1'b1, 6'd31, 32'h31, 5'h1F, 1'b1);
        step(1'b0, 6'd0, 32'h0, 5'h0, 1'b0);
        n_cmp++; if ({cnt, ovf, we, wa} !== {2'd2, 1'b1, 1'b1, 6'd30}) begin
            n_err++; $display("FAIL ar_pre got=%0d/%b/%b/%0d want=2/1/1/30", cnt, ovf, we, wa); end
        rst_ni = 1'b0; #1;
        n_cmp++; if ({cnt, ovf, we, fwe} !== {2'd0, 1'b0, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL ar_now got=%0d/%b/%b/%b want=0/0/0/0", cnt, ovf, we, fwe); end
        @(negedge clk); rst_ni = 1'b1;
        step(1'b0, 6'd0, 32'h0, 5'h0, 1'b0);
        n_cmp++; if ({cnt, we} !== {2'd0, 1'b0}) begin n_err++; $display("FAIL ar_after got=%0d/%b want=0/0", cnt, we); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_lsu_park();
        test_order();
        test_full_push_pop();
        test_read_dep();
        test_overflow();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
